// File: rtl/ahb_lite_slave_ram.sv
// AHB-Lite slave RAM: parametrised width/depth, wait states, byte-lane
// strobes, two-cycle ERROR response and write-to-read forwarding.
// Ports: HCLK/HRESET (async, active-high); address-phase inputs HSEL,
// HADDR, HTRANS, HWRITE, HSIZE, HBURST (ignored), HREADY; data-phase
// input HWDATA; outputs HREADYOUT, HRESP, HRDATA.
module ahb_lite_slave_ram #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 256,
    parameter int ADDR_WIDTH  = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [DATA_WIDTH-1:0] HRDATA
);

    localparam int NB = DATA_WIDTH / 8;
    localparam int LB = $clog2(NB);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WS_LOAD =
        (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ERR1,
        ERR2
    } state_t;

    state_t                state;
    state_t                state_n;
    logic [3:0]            cnt;
    logic [3:0]            cnt_n;

    logic                  pend;
    logic                  p_write;
    logic [2:0]            p_size;
    logic [LB-1:0]         p_off;
    logic [IW-1:0]         p_idx;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata;

    logic                  ready;
    logic                  take;
    logic                  a_err;
    logic                  commit;
    logic                  rd_now;
    logic                  rd_late;
    logic                  rd_load;
    logic [ADDR_WIDTH-1:0] a_word;
    logic [IW-1:0]         a_idx;
    logic [IW-1:0]         rd_idx;
    logic [NB-1:0]         strb;
    logic [DATA_WIDTH-1:0] merged;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  unused_bits;

    assign unused_bits = ^{HBURST, HTRANS[0]};

    function automatic logic [NB-1:0] lane_mask(
        input logic [2:0]    size,
        input logic [LB-1:0] off
    );
        logic [NB-1:0] m;
        m = '0;
        for (int b = 0; b < NB; b++) begin
            if (b >= int'(off) && b < int'(off) + (1 << size))
                m[b] = 1'b1;
        end
        return m;
    endfunction

    assign ready  = (state == IDLE) || (state == ERR2);
    assign take   = HSEL && HREADY && HTRANS[1] && ready;
    assign a_word = HADDR >> LB;
    assign a_idx  = a_word[IW-1:0];

    always_comb begin
        a_err = 1'b0;
        if ((1 << HSIZE) > NB)
            a_err = 1'b1;
        if ((int'(HADDR[LB-1:0]) & ((1 << HSIZE) - 1)) != 0)
            a_err = 1'b1;
        if (a_word >= ADDR_WIDTH'(DEPTH))
            a_err = 1'b1;
    end

    // The completing data cycle of a latched transfer is always spent in
    // IDLE, so the write commits on the edge leaving that cycle.
    assign commit = (state == IDLE) && pend && p_write;
    assign strb   = lane_mask(p_size, p_off);

    always_comb begin
        merged = mem[p_idx];
        for (int b = 0; b < NB; b++) begin
            if (strb[b])
                merged[8*b +: 8] = HWDATA[8*b +: 8];
        end
    end

    // Zero-wait reads load on the address edge; waited reads load on the
    // edge that leaves WAIT. A commit to the same word bypasses memory.
    assign rd_now  = take && !a_err && !HWRITE && (WAIT_STATES == 0);
    assign rd_late = (state == WAIT) && (cnt == 4'd0) && !p_write;
    assign rd_load = rd_now || rd_late;
    assign rd_idx  = rd_late ? p_idx : a_idx;
    assign rd_word = (commit && (p_idx == rd_idx)) ? merged : mem[rd_idx];

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            IDLE, ERR2: begin
                state_n = IDLE;
                if (take) begin
                    if (a_err) begin
                        state_n = ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_n = WAIT;
                        cnt_n   = WS_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0)
                    state_n = IDLE;
                else
                    cnt_n = cnt - 4'd1;
            end
            ERR1: state_n = ERR2;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            pend    <= 1'b0;
            p_write <= 1'b0;
            p_size  <= 3'd0;
            p_off   <= '0;
            p_idx   <= '0;
        end else if (ready) begin
            pend <= take && !a_err;
            if (take) begin
                p_write <= HWRITE;
                p_size  <= HSIZE;
                p_off   <= HADDR[LB-1:0];
                p_idx   <= a_idx;
            end
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            rdata <= '0;
        end else begin
            if (commit)
                mem[p_idx] <= merged;
            if (rd_load)
                rdata <= rd_word;
        end
    end

    assign HREADYOUT = ready;
    assign HRESP     = (state == ERR1) || (state == ERR2);
    assign HRDATA    = rdata;

endmodule

// File: tb/tb_ahb_lite_slave_ram.sv
// Bench for ahb_lite_slave_ram: one zero-wait and one 3-wait instance,
// byte-level reference memory and a read-data scoreboard queue.
module tb_ahb_lite_slave_ram;

    logic        clk = 1'b0;
    logic        rst;
    logic        hsel;
    logic        use3;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic        rdy0, rdy3, resp0, resp3;
    logic [31:0] rd0, rd3;
    logic        hreadyout, hresp;
    logic [31:0] hrdata;

    logic [7:0]  mdl [2][1024];
    logic [31:0] exp_q [$];
    int          total;
    int          bad;

    always #5 clk = ~clk;

    assign hreadyout = use3 ? rdy3 : rdy0;
    assign hresp     = use3 ? resp3 : resp0;
    assign hrdata    = use3 ? rd3 : rd0;

    ahb_lite_slave_ram #(
        .DATA_WIDTH(32), .DEPTH(256), .ADDR_WIDTH(32), .WAIT_STATES(0)
    ) dut0 (
        .HCLK(clk), .HRESET(rst), .HSEL(hsel && !use3), .HADDR(haddr),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst),
        .HWDATA(hwdata), .HREADY(rdy0), .HREADYOUT(rdy0), .HRESP(resp0),
        .HRDATA(rd0)
    );

    ahb_lite_slave_ram #(
        .DATA_WIDTH(32), .DEPTH(256), .ADDR_WIDTH(32), .WAIT_STATES(3)
    ) dut3 (
        .HCLK(clk), .HRESET(rst), .HSEL(hsel && use3), .HADDR(haddr),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst),
        .HWDATA(hwdata), .HREADY(rdy3), .HREADYOUT(rdy3), .HRESP(resp3),
        .HRDATA(rd3)
    );

    task automatic clear_models();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 1024; i++)
                mdl[d][i] = 8'h00;
    endtask

    function automatic bit legal(input logic [31:0] a, input logic [2:0] s);
        return (s <= 3'd2) && ((a % (32'd1 << s)) == 0) && ((a >> 2) < 256);
    endfunction

    task automatic mdl_write(input logic [31:0] a, input logic [2:0] s,
                             input logic [31:0] data);
        int b;
        for (int i = 0; i < (1 << s); i++) begin
            b = int'(a) + i;
            mdl[int'(use3)][b] = data[8*(b % 4) +: 8];
        end
    endtask

    function automatic logic [31:0] mdl_word(input logic [31:0] a);
        int w;
        w = int'(a) & ~3;
        return {mdl[int'(use3)][w+3], mdl[int'(use3)][w+2],
                mdl[int'(use3)][w+1], mdl[int'(use3)][w]};
    endfunction

    // Single non-pipelined transfer; entered and left just after a posedge.
    task automatic bus_xfer(input bit wr, input logic [31:0] a,
                            input logic [2:0] s, input logic [31:0] wd,
                            output int lows, output bit lresp,
                            output bit fresp, output logic [31:0] rd);
        hsel = 1'b1; htrans = 2'd2; haddr = a; hwrite = wr; hsize = s;
        hburst = 3'd0;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'd0; hwdata = wd;
        lows = 0; lresp = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (hreadyout) break;
            lows++;
            lresp = lresp | hresp;
        end
        if (!hreadyout) lows = 999;
        fresp = hresp;
        rd = hrdata;
        @(posedge clk); #1;
        if (wr && legal(a, s)) mdl_write(a, s, wd);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (rdy0 !== 1'b1 || rdy3 !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: got %b/%b want 1/1", rdy0, rdy3);
        end
        total++;
        if (resp0 !== 1'b0 || resp3 !== 1'b0) begin
            bad++;
            $display("FAIL reset_resp: got %b/%b want 0/0", resp0, resp3);
        end
        total++;
        if (rd0 !== 32'h0 || rd3 !== 32'h0) begin
            bad++;
            $display("FAIL reset_rdata: got %h/%h want 0", rd0, rd3);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_word_rw();
        int lows; bit lr, fr; logic [31:0] rd, e;
        use3 = 1'b0;
        bus_xfer(1'b1, 32'h10, 3'd2, 32'hDEADBEEF, lows, lr, fr, rd);
        total++;
        if (lows !== 0 || lr || fr) begin
            bad++;
            $display("FAIL word_write: got waits=%0d resp=%b want 0/0", lows, fr);
        end
        exp_q.push_back(mdl_word(32'h10));
        bus_xfer(1'b0, 32'h10, 3'd2, 32'h0, lows, lr, fr, rd);
        e = exp_q.pop_front();
        total++;
        if (lows !== 0 || fr || rd !== e) begin
            bad++;
            $display("FAIL word_read: got waits=%0d resp=%b data=%h want 0/0/%h",
                     lows, fr, rd, e);
        end
    endtask

    task automatic test_strobes();
        int lows; bit lr, fr; logic [31:0] rd, e;
        use3 = 1'b0;
        bus_xfer(1'b1, 32'h20, 3'd2, 32'h11223344, lows, lr, fr, rd);
        bus_xfer(1'b1, 32'h22, 3'd0, 32'h00AA0000, lows, lr, fr, rd);
        exp_q.push_back(32'h11AA3344);
        bus_xfer(1'b0, 32'h20, 3'd2, 32'h0, lows, lr, fr, rd);
        e = exp_q.pop_front();
        total++;
        if (rd !== e) begin
            bad++;
            $display("FAIL byte_strobe: got %h want %h", rd, e);
        end
        bus_xfer(1'b1, 32'h24, 3'd2, 32'h01020304, lows, lr, fr, rd);
        bus_xfer(1'b1, 32'h26, 3'd1, 32'hBEEF0000, lows, lr, fr, rd);
        exp_q.push_back(mdl_word(32'h24));
        bus_xfer(1'b0, 32'h24, 3'd2, 32'h0, lows, lr, fr, rd);
        e = exp_q.pop_front();
        total++;
        if (rd !== e) begin
            bad++;
            $display("FAIL half_strobe: got %h want %h", rd, e);
        end
    endtask

    task automatic test_waits();
        int lows; bit lr, fr; logic [31:0] rd, e;
        use3 = 1'b1;
        bus_xfer(1'b1, 32'h8, 3'd2, 32'hCAFEF00D, lows, lr, fr, rd);
        total++;
        if (lows !== 3 || lr || fr) begin
            bad++;
            $display("FAIL wait_write: got waits=%0d resp=%b want 3/0", lows, fr);
        end
        exp_q.push_back(mdl_word(32'h8));
        bus_xfer(1'b0, 32'h8, 3'd2, 32'h0, lows, lr, fr, rd);
        e = exp_q.pop_front();
        total++;
        if (lows !== 3 || lr || fr || rd !== e) begin
            bad++;
            $display("FAIL wait_read: got waits=%0d data=%h want 3/%h", lows, rd, e);
        end
    endtask

    task automatic test_burst();
        int cyc, done, nxt; logic [31:0] e;
        use3 = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(mdl_word(32'(i * 4)));
        hsel = 1'b1; htrans = 2'd2; hburst = 3'd3; hwrite = 1'b0;
        hsize = 3'd2; haddr = 32'h0;
        @(posedge clk); #1;
        nxt = 1; haddr = 32'h4; htrans = 2'd3;
        cyc = 0; done = 0;
        while (done < 4 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (hreadyout) begin
                e = exp_q.pop_front();
                total++;
                if (hrdata !== e || hresp !== 1'b0) begin
                    bad++;
                    $display("FAIL burst_beat%0d: got %h want %h", done, hrdata, e);
                end
                done++;
                @(posedge clk); #1;
                nxt++;
                if (nxt < 4) begin
                    haddr = 32'(nxt * 4);
                end else begin
                    hsel = 1'b0; htrans = 2'd0;
                end
            end
        end
        hsel = 1'b0; htrans = 2'd0; hburst = 3'd0;
        exp_q.delete();
        total++;
        if (done != 4 || cyc != 16) begin
            bad++;
            $display("FAIL burst_cycles: got %0d beats in %0d cycles want 4 in 16",
                     done, cyc);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_errors();
        int lows; bit lr, fr; logic [31:0] rd, e, held;
        logic [31:0] ea [3];
        logic [2:0]  es [3];
        ea[0] = 32'h400; es[0] = 3'd2;
        ea[1] = 32'h3;   es[1] = 3'd1;
        ea[2] = 32'h8;   es[2] = 3'd3;
        use3 = 1'b0;
        bus_xfer(1'b1, 32'h0, 3'd2, 32'hA5A5A5A5, lows, lr, fr, rd);
        bus_xfer(1'b1, 32'h8, 3'd2, 32'h5A5A5A5A, lows, lr, fr, rd);
        for (int k = 0; k < 3; k++) begin
            bus_xfer(1'b1, ea[k], es[k], 32'hFFFFFFFF, lows, lr, fr, rd);
            total++;
            if (lows !== 1 || !lr || !fr) begin
                bad++;
                $display("FAIL err%0d: got low=%0d resp=%b/%b want 1/1/1",
                         k, lows, lr, fr);
            end
        end
        exp_q.push_back(mdl_word(32'h0));
        bus_xfer(1'b0, 32'h0, 3'd2, 32'h0, lows, lr, fr, rd);
        held = exp_q.pop_front();
        total++;
        if (rd !== held) begin
            bad++;
            $display("FAIL err_mem0: got %h want %h", rd, held);
        end
        bus_xfer(1'b0, 32'h404, 3'd2, 32'h0, lows, lr, fr, rd);
        total++;
        if (lows !== 1 || !fr || rd !== held) begin
            bad++;
            $display("FAIL err_read_hold: got low=%0d data=%h want 1/%h",
                     lows, rd, held);
        end
        exp_q.push_back(mdl_word(32'h8));
        bus_xfer(1'b0, 32'h8, 3'd2, 32'h0, lows, lr, fr, rd);
        e = exp_q.pop_front();
        total++;
        if (rd !== e) begin
            bad++;
            $display("FAIL err_mem8: got %h want %h", rd, e);
        end
    endtask

    task automatic test_forward();
        int lows; bit lr, fr; logic [31:0] rd, e;
        use3 = 1'b0;
        bus_xfer(1'b1, 32'h40, 3'd2, 32'h12345678, lows, lr, fr, rd);
        hsel = 1'b1; htrans = 2'd2; hwrite = 1'b1; hsize = 3'd0;
        haddr = 32'h40;
        @(posedge clk); #1;
        hwdata = 32'h00000055;
        mdl_write(32'h40, 3'd0, 32'h00000055);
        hwrite = 1'b0; hsize = 3'd2; haddr = 32'h40;
        exp_q.push_back(mdl_word(32'h40));
        @(negedge clk);
        total++;
        if (hreadyout !== 1'b1) begin
            bad++;
            $display("FAIL fwd_write_stall: got ready=%b want 1", hreadyout);
        end
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'd0;
        @(negedge clk);
        e = exp_q.pop_front();
        total++;
        if (hreadyout !== 1'b1 || hresp !== 1'b0 || hrdata !== e) begin
            bad++;
            $display("FAIL forward: got ready=%b data=%h want 1/%h",
                     hreadyout, hrdata, e);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] wd [4];
        logic [31:0] e, last;
        use3 = 1'b0;
        last = 32'h0;
        for (int i = 0; i < 4; i++) wd[i] = $urandom;
        for (int k = 0; k <= 8; k++) begin
            if (k >= 1 && k <= 4) begin
                hwdata = wd[k-1];
                mdl_write(32'h80 + 32'(4 * (k - 1)), 3'd2, wd[k-1]);
            end
            if (k < 8) begin
                hsel = 1'b1;
                htrans = (k == 0 || k == 4) ? 2'd2 : 2'd3;
                hwrite = (k < 4);
                hsize = 3'd2;
                haddr = 32'h80 + 32'(4 * (k % 4));
                if (k >= 4) exp_q.push_back(mdl_word(haddr));
            end else begin
                hsel = 1'b0; htrans = 2'd0;
            end
            if (k >= 1) begin
                @(negedge clk);
                total++;
                if (hreadyout !== 1'b1 || hresp !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_stall%0d: got ready=%b resp=%b want 1/0",
                             k - 1, hreadyout, hresp);
                end
                if (k >= 5) begin
                    e = exp_q.pop_front();
                    last = e;
                    total++;
                    if (hrdata !== e) begin
                        bad++;
                        $display("FAIL b2b_read%0d: got %h want %h", k - 5, hrdata, e);
                    end
                end
            end
            @(posedge clk); #1;
        end
        hsel = 1'b1; htrans = 2'd1;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'd0;
        @(negedge clk);
        total++;
        if (hreadyout !== 1'b1 || hresp !== 1'b0 || hrdata !== last) begin
            bad++;
            $display("FAIL busy: got ready=%b resp=%b data=%h want 1/0/%h",
                     hreadyout, hresp, hrdata, last);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int lows; bit lr, fr; logic [31:0] rd, e;
        use3 = 1'b1;
        hsel = 1'b1; htrans = 2'd2; hwrite = 1'b1; hsize = 3'd2;
        haddr = 32'h30;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'd0; hwdata = 32'h77777777;
        @(negedge clk);
        total++;
        if (hreadyout !== 1'b0) begin
            bad++;
            $display("FAIL mid_wait: got ready=%b want 0", hreadyout);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        clear_models();
        total++;
        if (hreadyout !== 1'b1 || hresp !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: got ready=%b resp=%b want 1/0",
                     hreadyout, hresp);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        exp_q.push_back(mdl_word(32'h30));
        bus_xfer(1'b0, 32'h30, 3'd2, 32'h0, lows, lr, fr, rd);
        e = exp_q.pop_front();
        total++;
        if (lows !== 3 || fr || rd !== e) begin
            bad++;
            $display("FAIL mid_readback: got waits=%0d data=%h want 3/%h",
                     lows, rd, e);
        end
        use3 = 1'b0;
        exp_q.push_back(mdl_word(32'h10));
        bus_xfer(1'b0, 32'h10, 3'd2, 32'h0, lows, lr, fr, rd);
        e = exp_q.pop_front();
        total++;
        if (rd !== e) begin
            bad++;
            $display("FAIL mid_clear0: got %h want %h", rd, e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0; bad = 0;
        rst = 1'b1; hsel = 1'b0; use3 = 1'b0; haddr = 32'h0;
        htrans = 2'd0; hwrite = 1'b0; hsize = 3'd0; hburst = 3'd0;
        hwdata = 32'h0;
        clear_models();
        test_reset();
        test_word_rw();
        test_strobes();
        test_waits();
        test_burst();
        test_errors();
        test_forward();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ahb_lite_slave_ram.md
Name: ahb_lite_slave_ram

Overview:
- Parametrised AHB-Lite slave RAM. Next-generation DUT for the AHB slave verification environment.
- Adds configurable data width, depth and wait states over the fixed-size slave.
- Adds byte/halfword/word write strobing, two-cycle ERROR responses and write-to-read forwarding.
- Sits behind the interconnect decoder/mux: takes HSEL, returns HREADYOUT/HRESP/HRDATA.

Parameters:
- DATA_WIDTH, 32, HWDATA/HRDATA width in bits; 32 or 64 only.
- DEPTH, 256, number of DATA_WIDTH-bit words.
- ADDR_WIDTH, 32, HADDR width.
- WAIT_STATES, 0, HREADYOUT-low cycles inserted in every OKAY data phase; range 0..15.

Ports:
- HCLK  input  1  clock; all logic on the rising edge.
- HRESET  input  1  asynchronous reset, active-high.
- HSEL  input  1  slave select from decoder.
- HADDR  input  ADDR_WIDTH  byte address.
- HTRANS  input  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HWRITE  input  1  1 = write.
- HSIZE  input  3  0 = byte, 1 = half, 2 = word, 3 = dword.
- HBURST  input  3  accepted, not used functionally.
- HWDATA  input  DATA_WIDTH  write data, valid in the data phase.
- HREADY  input  1  bus-level ready from the mux.
- HREADYOUT  output  1  slave ready.
- HRESP  output  1  0 = OKAY, 1 = ERROR.
- HRDATA  output  DATA_WIDTH  read data.

Behaviour:
- Reset values (HRESET=1, applied asynchronously):
  - HREADYOUT=1, HRESP=0, HRDATA=0.
  - FSM goes to IDLE; latched control is cleared.
  - Every memory word is cleared to 0.
- Address phase is sampled on an edge where HSEL & HREADY = 1.
  - HTRANS[1]=1: transfer is active. Latch HADDR, HSIZE, HWRITE.
  - Otherwise (IDLE, BUSY, or HSEL=0): no transfer. The next cycle is OKAY with HREADYOUT=1 and zero wait states.
- Error check, done at address-phase capture. The transfer is in error if any of these holds:
  - (1<<HSIZE) > DATA_WIDTH/8;
  - HADDR is not aligned to the transfer size;
  - word index HADDR >> log2(DATA_WIDTH/8) >= DEPTH.
- FSM states: IDLE, WAIT, ERR1, ERR2.
- IDLE:
  - Active error transfer -> ERR1.
  - Active OKAY transfer with WAIT_STATES>0 -> WAIT, wait counter loaded with WAIT_STATES-1.
  - Active OKAY transfer with WAIT_STATES=0 -> stays in IDLE; the data phase completes in the next cycle.
- WAIT:
  - HREADYOUT=0, HRESP=0.
  - Counter decrements each cycle. At 0 -> IDLE, and the following cycle is the completing data cycle with HREADYOUT=1.
- ERR1: HREADYOUT=0, HRESP=1 -> ERR2.
- ERR2: HREADYOUT=1, HRESP=1.
  - A new address phase sampled on the ERR2 completion edge is processed normally.
  - The master may drive IDLE there to cancel the rest of a burst.
- Errors never add wait states and never modify memory. HRDATA holds its previous value during an error.
- Write commit:
  - Happens on the edge that ends the completing data cycle, i.e. HREADYOUT=1 with an OKAY response.
  - Only byte lanes selected by HSIZE and HADDR[log2(DATA_WIDTH/8)-1:0] are written; byte order is little-endian.
  - Unselected bytes are preserved.
- Read data:
  - HRDATA is registered and loaded on the edge that begins the completing data cycle.
  - With WAIT_STATES=0, that edge is the address-phase edge.
  - All DATA_WIDTH bits are returned, word-aligned; the master selects lanes.
  - HRDATA holds its value outside read completions.
- Forwarding: if a write commit to word W happens on the same edge that HRDATA is loaded for a read of W, HRDATA returns the merged post-write word. Reads never return stale data.
- Back-to-back pipelined transfers (NONSEQ/SEQ) with WAIT_STATES=0 run at 1 transfer per cycle.
- HBURST is ignored. Wrap and increment bursts work because each beat carries its own HADDR.
- BUSY inside a burst produces a zero-wait OKAY and no memory access.
- When HREADY=0 (another slave is stalling), no address phase is sampled and the FSM state is held.
- HRESET asserted mid-transfer (in WAIT, ERR1 or ERR2):
  - Outputs return to reset values immediately.
  - A pending write is discarded.
  - Memory is cleared.

Test Plan:
- Reset, then WAIT_STATES=0: write word 0xDEADBEEF to 0x10, then read 0x10 -> OKAY, HREADYOUT stays 1, HRDATA=0xDEADBEEF.
- Byte strobes: word write 0x11223344 to 0x20, byte write 0xAA to 0x22, read 0x20 -> HRDATA=0x11AA3344.
- WAIT_STATES=3: single read -> HREADYOUT low for exactly 3 cycles, then high with data. An INCR4 burst takes 16 cycles of data phase.
- Error cases, each -> ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1):
  - DEPTH=256, DATA_WIDTH=32, address 0x400;
  - half write to 0x03;
  - HSIZE=3 at DATA_WIDTH=32.
  Memory is unchanged in all three.
- Forwarding: pipelined write 0x55 (byte) to 0x40 immediately followed by a read of 0x40, with WAIT_STATES=0 -> HRDATA byte0=0x55 with no stall.
- Assert HRESET during the 2nd WAIT cycle of a write -> HREADYOUT=1, HRESP=0 at once. A later read of that address returns 0.
